feature_window_buffer: RTL and testbench
========================================

Name: feature_window_buffer

Overview:
- Frame buffer for one convolution-result feature map (N_R x N_C), written as a raster stream with an internal write pointer.
- On start, an internal FSM scans the map with a WIN x WIN window at STRIDE and emits each window as one flat word over a valid/ready handshake.
- Sits between the conv result stage and the pooling/next-layer stage.
- Generalises the fixed 26x26, 2x2, externally addressed result memory: sizes, window and stride are parameters, and addressing is internal.

Parameters:
- N_C, 26, feature-map columns
- N_R, 26, feature-map rows
- DATA_W, 8, element width (signed two's complement)
- WIN, 2, window edge (2..4)
- STRIDE, 2, window step in both directions (1..WIN)
- ADDR_W, 10, memory address width; must satisfy 2^ADDR_W >= N_R*N_C
- IDX_W, 5, width of window row/col index outputs

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- wen  in  1  write strobe for data_in
- data_in  in  DATA_W  pixel, raster order (row-major)
- clear  in  1  zero the write pointer, drop the loaded frame
- wr_full  out  1  N_R*N_C pixels stored
- start  in  1  begin scan (sampled only in IDLE)
- busy  out  1  high from start accepted until DONE exits
- win_valid  out  1  window word valid
- win_ready  in  1  consumer accepts window
- win_data  out  WIN*WIN*DATA_W  element (i,j) at bits [(i*WIN+j)*DATA_W +: DATA_W]
- win_row  out  IDX_W  output row index of current window
- win_col  out  IDX_W  output column index of current window
- win_last  out  1  current window is the final one
- done  out  1  one-cycle pulse after the last window is accepted

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; write pointer=0.
  - wr_full, busy, win_valid, win_last, done = 0; win_data, win_row, win_col = 0.
  - Memory contents are not reset.
  - Reset mid-scan aborts at once; no done pulse.
- Write path (IDLE only):
  - wen with wr_full=0: mem[wptr]<=data_in, wptr++.
  - wr_full=1 when wptr==N_R*N_C.
  - wen while wr_full=1 or busy=1 is ignored.
  - clear in IDLE: wptr=0, wr_full=0. clear has priority over a same-cycle wen (the write is dropped).
- Output grid:
  - OC = (N_C-WIN)/STRIDE+1 windows per row; OR = (N_R-WIN)/STRIDE+1 window rows (integer division).
  - Window (r,c) has its top-left element at address (r*STRIDE)*N_C + c*STRIDE.
- FSM states IDLE, READ, OUT, DONE:
  - IDLE:
    - start with wr_full=1: r=c=0, busy=1, go to READ.
    - start with wr_full=0: ignored.
  - READ: register all WIN*WIN elements of window (r,c) into win_data; win_row=r, win_col=c; win_last=(r==OR-1 && c==OC-1). Go to OUT.
  - OUT:
    - win_valid=1.
    - win_data, win_row, win_col and win_last hold stable until win_ready.
    - On win_valid&&win_ready: if win_last, go to DONE; else c++ (at c==OC-1: c=0, r++), then go to READ.
  - DONE: done=1 for one cycle; wptr=0, wr_full=0, busy=0; go to IDLE.
- Timing:
  - Latency start -> first win_valid: 2 cycles.
  - Throughput: 1 window per 2 cycles with win_ready tied high.
- start and clear outside IDLE are ignored.

Optional Feature:
- Macro: WINDOW_MAX_EN.
- When defined: extra output port win_max [DATA_W-1:0], the signed maximum of the WIN*WIN elements.
  - Registered in READ alongside win_data.
  - Reset value 0; same stability rules as win_data.
- When undefined: the port and its comparator tree are absent; all other behaviour is identical.

Test Plan:
- Ramp frame (26x26, data_in = index mod 256), start, win_ready=1 -> exactly 169 windows. First window {0,1,26,27}, row=0, col=0. Last window {136,137,162,163}, row=12, col=12, win_last=1. done pulses once.
- Same frame, win_ready toggled pseudo-randomly -> win_data stable while win_valid&&!win_ready; no window lost or duplicated; window order identical to the previous case.
- Write 677 pixels -> wr_full=1 after the 676th write; 677th write ignored. start with wr_full=0 after clear -> busy stays 0.
- rst_n=0 during window 50 -> next cycle win_valid=0, busy=0, wr_full=0; no done pulse. Reload and rescan -> window 0 correct.
- Build with WIN=3, STRIDE=1 -> 576 windows; window (0,0) = {0,1,2,26,27,28,52,53,54}.
- WINDOW_MAX_EN defined; window loaded with {-5,3,-128,2} -> win_max=3. All-negative window {-1,-7,-128,-2} -> win_max=-1.

Source files
------------

// File: rtl/feature_window_buffer.sv
// feature_window_buffer: frame buffer for one N_R x N_C feature map.
// A raster stream fills the buffer through an internal write pointer. A start
// request then scans the map with a WIN x WIN window at STRIDE and presents
// each window as one flat word on a valid/ready interface.
// Optional build macro: WINDOW_MAX_EN adds win_max, the signed maximum of the
// window elements, registered together with win_data.
module feature_window_buffer #(
  parameter int unsigned N_C    = 26,
  parameter int unsigned N_R    = 26,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 2,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned IDX_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wen,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         clear,
  output logic                         wr_full,
  input  logic                         start,
  output logic                         busy,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic [WIN*WIN*DATA_W-1:0]    win_data,
  output logic [IDX_W-1:0]             win_row,
  output logic [IDX_W-1:0]             win_col,
  output logic                         win_last,
`ifdef WINDOW_MAX_EN
  output logic [DATA_W-1:0]            win_max,
`endif
  output logic                         done
);

  localparam int unsigned TOTAL = N_R * N_C;
  localparam int unsigned N_OC  = (N_C - WIN) / STRIDE + 1;
  localparam int unsigned N_OR  = (N_R - WIN) / STRIDE + 1;
  localparam int unsigned NE    = WIN * WIN;
  localparam int unsigned WD    = NE * DATA_W;

  typedef enum logic [1:0] {IDLE, READ, OUT, DONE} state_t;

  state_t              state;
  state_t              state_nxt;

  logic [DATA_W-1:0]   mem [TOTAL];
  logic [ADDR_W:0]     wptr;
  logic [IDX_W-1:0]    row_idx;
  logic [IDX_W-1:0]    col_idx;
  logic [ADDR_W-1:0]   row_base;
  logic [ADDR_W-1:0]   col_off;
  logic [WD-1:0]       win_nxt;
  logic                at_last;
  logic                start_ok;
  logic                wr_ok;
  logic                accept;

  assign wr_full  = (wptr == (ADDR_W+1)'(TOTAL));
  assign start_ok = (state == IDLE) && start && wr_full;
  assign wr_ok    = (state == IDLE) && wen && !clear && !wr_full;
  assign accept   = (state == OUT) && win_ready;
  assign at_last  = (row_idx == IDX_W'(N_OR - 1)) && (col_idx == IDX_W'(N_OC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded handshake/status outputs
  always_comb begin
    state_nxt = state;
    win_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = READ;
      end
      READ: state_nxt = OUT;
      OUT: begin
        win_valid = 1'b1;
        if (win_ready) state_nxt = win_last ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel storage; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_W-1:0]] <= data_in;
  end

  // Write pointer: advances on accepted writes, rewinds on clear or scan end
  always_ff @(posedge clk) begin
    if (!rst_n)                       wptr <= '0;
    else if (state == DONE)           wptr <= '0;
    else if (state == IDLE && clear)  wptr <= '0;
    else if (wr_ok)                   wptr <= wptr + (ADDR_W+1)'(1);
  end

  // Scan position; row_base/col_off track the top-left address incrementally
  // so no multiplier is needed for the window origin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_idx  <= '0;
      col_idx  <= '0;
      row_base <= '0;
      col_off  <= '0;
    end else if (start_ok) begin
      row_idx  <= '0;
      col_idx  <= '0;
      row_base <= '0;
      col_off  <= '0;
    end else if (accept && !win_last) begin
      if (col_idx == IDX_W'(N_OC - 1)) begin
        col_idx  <= '0;
        col_off  <= '0;
        row_idx  <= row_idx + IDX_W'(1);
        row_base <= row_base + ADDR_W'(STRIDE * N_C);
      end else begin
        col_idx  <= col_idx + IDX_W'(1);
        col_off  <= col_off + ADDR_W'(STRIDE);
      end
    end
  end

  // Gather all window elements from the origin plus constant per-element offsets
  always_comb begin
    win_nxt = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      for (int unsigned j = 0; j < WIN; j++) begin
        win_nxt[(i*WIN+j)*DATA_W +: DATA_W] =
          mem[row_base + col_off + ADDR_W'(i*N_C + j)];
      end
    end
  end

`ifdef WINDOW_MAX_EN
  logic signed [DATA_W-1:0] max_nxt;
  logic signed [DATA_W-1:0] elem;

  // Signed maximum over the gathered window elements
  always_comb begin
    elem    = '0;
    max_nxt = $signed(win_nxt[DATA_W-1:0]);
    for (int unsigned k = 1; k < NE; k++) begin
      elem = $signed(win_nxt[k*DATA_W +: DATA_W]);
      if (elem > max_nxt) max_nxt = elem;
    end
  end
`endif

  // Window output registers: loaded in READ, held through OUT until accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_data <= '0;
      win_row  <= '0;
      win_col  <= '0;
      win_last <= 1'b0;
`ifdef WINDOW_MAX_EN
      win_max  <= '0;
`endif
    end else if (state == READ) begin
      win_data <= win_nxt;
      win_row  <= row_idx;
      win_col  <= col_idx;
      win_last <= at_last;
`ifdef WINDOW_MAX_EN
      win_max  <= max_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_feature_window_buffer.sv
// Testbench for feature_window_buffer: table-driven window checks, a reference
// model computed from the window-grid rules, and hand-written corner sequences.
// A second instance (WIN=3, STRIDE=1) shares the write/start inputs.
module tb_feature_window_buffer;

  localparam int NC  = 26;
  localparam int NR  = 26;
  localparam int TOT = NC * NR;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        win_ready = 1'b0;
  logic [7:0]  data_in = '0;

  logic        wr_full, busy, win_valid, win_last, done;
  logic [31:0] win_data;
  logic [4:0]  win_row, win_col;

  logic        wr_full3, busy3, win_valid3, win_last3, done3;
  logic [71:0] win_data3;
  logic [4:0]  win_row3, win_col3;
`ifdef WINDOW_MAX_EN
  logic [7:0]  win_max, win_max3;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] frame [TOT];

  typedef struct {
    logic [127:0] data;
    int           row;
    int           col;
    bit           last;
    logic [7:0]   mx;
  } win_t;

  typedef struct {
    int           k;
    int           row;
    int           col;
    logic [127:0] data;
    bit           last;
  } vec_t;

  win_t q[$];
  win_t q_ref[$];
  win_t q3[$];
  win_t w3;
  bit   mon3_en = 1'b0;
  vec_t tbl [5];

  int first_valid;
  int done_cyc;
  int n_done;
  int stall_bad;

  feature_window_buffer #(
    .N_C(26), .N_R(26), .DATA_W(8), .WIN(2), .STRIDE(2), .ADDR_W(10), .IDX_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .data_in(data_in), .clear(clear),
    .wr_full(wr_full), .start(start), .busy(busy), .win_valid(win_valid),
    .win_ready(win_ready), .win_data(win_data), .win_row(win_row),
    .win_col(win_col), .win_last(win_last),
`ifdef WINDOW_MAX_EN
    .win_max(win_max),
`endif
    .done(done)
  );

  feature_window_buffer #(
    .N_C(26), .N_R(26), .DATA_W(8), .WIN(3), .STRIDE(1), .ADDR_W(10), .IDX_W(5)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .data_in(data_in), .clear(clear),
    .wr_full(wr_full3), .start(start), .busy(busy3), .win_valid(win_valid3),
    .win_ready(1'b1), .win_data(win_data3), .win_row(win_row3),
    .win_col(win_col3), .win_last(win_last3),
`ifdef WINDOW_MAX_EN
    .win_max(win_max3),
`endif
    .done(done3)
  );

  always #5 clk = ~clk;

  // Collect every window the WIN=3 instance hands over
  always @(posedge clk) begin
    if (mon3_en && rst_n && win_valid3) begin
      w3.data = 128'(win_data3);
      w3.row  = int'(win_row3);
      w3.col  = int'(win_col3);
      w3.last = win_last3;
`ifdef WINDOW_MAX_EN
      w3.mx   = win_max3;
`else
      w3.mx   = '0;
`endif
      q3.push_back(w3);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int n_windows(input int w, input int s);
    return ((NR - w) / s + 1) * ((NC - w) / s + 1);
  endfunction

  function automatic logic [127:0] model_data(input int w, input int s, input int k);
    int oc = (NC - w) / s + 1;
    int r  = k / oc;
    int c  = k % oc;
    logic [127:0] v = '0;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        v[(i*w+j)*8 +: 8] = frame[(r*s+i)*NC + c*s + j];
    return v;
  endfunction

  function automatic logic [7:0] model_max(input int w, input int s, input int k);
    int oc = (NC - w) / s + 1;
    int r  = k / oc;
    int c  = k % oc;
    logic signed [7:0] m = -128;
    logic signed [7:0] e;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++) begin
        e = frame[(r*s+i)*NC + c*s + j];
        if (e > m) m = e;
      end
    return m;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode 0: ramp, 1: random, 2: random with two fixed windows for the max test
  task automatic prepare_frame(input int mode);
    for (int i = 0; i < TOT; i++)
      frame[i] = (mode == 0) ? 8'(i) : 8'($urandom);
    if (mode == 2) begin
      frame[0] = 8'hfb; frame[1] = 8'h03; frame[26] = 8'h80; frame[27] = 8'h02;
      frame[2] = 8'hff; frame[3] = 8'hf9; frame[28] = 8'h80; frame[29] = 8'hfe;
    end
  endtask

  task automatic write_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      wen = 1'b1;
      data_in = frame[i];
      @(posedge clk);
      #1;
    end
    wen = 1'b0;
  endtask

  task automatic run_scan(input bit rnd_ready, input bit noise);
    win_t w;
    win_t hold;
    bit held = 1'b0;
    int cyc = 0;
    q.delete();
    first_valid = -1;
    done_cyc = -1;
    n_done = 0;
    stall_bad = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (done_cyc < 0 && cyc < 4000) begin
      win_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        clear   = ($urandom_range(0, 3) == 0);
        wen     = ($urandom_range(0, 1) == 0);
        start   = ($urandom_range(0, 3) == 0);
        data_in = 8'($urandom);
      end
      if (win_valid) begin
        if (first_valid < 0) first_valid = cyc;
        w.data = 128'(win_data);
        w.row  = int'(win_row);
        w.col  = int'(win_col);
        w.last = win_last;
`ifdef WINDOW_MAX_EN
        w.mx   = win_max;
`else
        w.mx   = '0;
`endif
        if (held && (w.data !== hold.data || w.row != hold.row || w.col != hold.col ||
                     w.last != hold.last || w.mx !== hold.mx))
          stall_bad++;
        if (win_ready) begin
          q.push_back(w);
          held = 1'b0;
        end else begin
          held = 1'b1;
          hold = w;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    clear = 1'b0;
    wen   = 1'b0;
    start = 1'b0;
    win_ready = 1'b1;
  endtask

  task automatic verify_model(input bit use3, input string tag);
    int w  = use3 ? 3 : 2;
    int s  = use3 ? 1 : 2;
    int n  = n_windows(w, s);
    int oc = (NC - w) / s + 1;
    int sz = use3 ? q3.size() : q.size();
    win_t x;
    check({tag, "_count"}, 128'(sz), 128'(n));
    for (int k = 0; k < sz && k < n; k++) begin
      x = use3 ? q3[k] : q[k];
      check({tag, "_data"}, x.data, model_data(w, s, k));
      check({tag, "_pos"}, 128'(x.row * 64 + x.col * 2 + int'(x.last)),
            128'((k / oc) * 64 + (k % oc) * 2 + ((k == n - 1) ? 1 : 0)));
`ifdef WINDOW_MAX_EN
      check({tag, "_max"}, 128'(x.mx), 128'(model_max(w, s, k)));
`endif
    end
  endtask

  initial begin
    int cnt;
    int acc;
    bit seen_done;

    tbl[0] = '{0,   0,  0,  128'h1b1a0100, 1'b0};
    tbl[1] = '{1,   0,  1,  128'h1d1c0302, 1'b0};
    tbl[2] = '{12,  0,  12, 128'h33321918, 1'b0};
    tbl[3] = '{13,  1,  0,  128'h4f4e3534, 1'b0};
    tbl[4] = '{168, 12, 12, 128'ha3a28988, 1'b1};

    do_reset();
    check("rst_wr_full",   128'(wr_full), 0);
    check("rst_busy",      128'(busy), 0);
    check("rst_win_valid", 128'(win_valid), 0);
    check("rst_done",      128'(done), 0);
    check("rst_win_last",  128'(win_last), 0);
    check("rst_win_data",  128'(win_data), 0);
    check("rst_row_col",   128'({win_row, win_col}), 0);

    // start with nothing loaded is ignored
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_empty_busy", 128'(busy), 0);
    @(posedge clk);
    #1 check("start_empty_valid", 128'(win_valid), 0);

    // fill boundary: full exactly after the 676th write, extra write ignored
    prepare_frame(0);
    write_range(0, TOT - 1);
    check("wr_full_675", 128'(wr_full), 0);
    write_range(TOT - 1, TOT);
    check("wr_full_676", 128'(wr_full), 1);
    wen = 1'b1; data_in = 8'haa;
    @(posedge clk);
    #1 wen = 1'b0;
    check("wr_full_677", 128'(wr_full), 1);

    // ramp scan with ready tied high
    q3.delete();
    mon3_en = 1'b1;
    run_scan(1'b0, 1'b0);
    check("ramp_done_seen",  128'(done_cyc >= 0), 1);
    check("ramp_latency",    128'(first_valid), 1);
    check("ramp_done_cycle", 128'(done_cyc), 338);
    check("ramp_busy_done",  128'(busy), 1);
    @(posedge clk);
    #1;
    check("done_one_cycle",     128'(done), 0);
    check("busy_after_done",    128'(busy), 0);
    check("wr_full_after_done", 128'(wr_full), 0);
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].k < q.size()) begin
        check("tbl_data", q[tbl[i].k].data, tbl[i].data);
        check("tbl_pos", 128'(q[tbl[i].k].row * 64 + q[tbl[i].k].col * 2 + int'(q[tbl[i].k].last)),
              128'(tbl[i].row * 64 + tbl[i].col * 2 + int'(tbl[i].last)));
      end else begin
        check("tbl_present", 128'(q.size()), 128'(tbl[i].k + 1));
      end
    end
    verify_model(1'b0, "ramp");
    q_ref = q;

    // WIN=3 STRIDE=1 instance finishes its 576-window scan
    cnt = 0;
    while (busy3 && cnt < 3000) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("w3_finished", 128'(busy3), 0);
    mon3_en = 1'b0;
    if (q3.size() > 0) check("w3_first", q3[0].data, 128'h363534_1c1b1a_020100);
    else               check("w3_first_present", 128'(q3.size()), 576);
    verify_model(1'b1, "w3");

    // same frame, random back-pressure: same windows in same order, stable while stalled
    prepare_frame(0);
    write_range(0, TOT);
    run_scan(1'b1, 1'b0);
    check("bp_done_seen", 128'(done_cyc >= 0), 1);
    check("bp_count", 128'(q.size()), 128'(q_ref.size()));
    check("bp_stable", 128'(stall_bad), 0);
    check("bp_done_once", 128'(n_done), 1);
    for (int k = 0; k < q.size() && k < q_ref.size(); k++)
      check("bp_order", q[k].data, q_ref[k].data);
    @(posedge clk);
    #1;

    // random frames, back-pressure, and clear/wen/start noise during the scan
    for (int t = 0; t < 2; t++) begin
      prepare_frame(1);
      write_range(0, TOT);
      run_scan(1'b1, 1'b1);
      check("rnd_done_seen", 128'(done_cyc >= 0), 1);
      check("rnd_stable", 128'(stall_bad), 0);
      verify_model(1'b0, "rnd");
      @(posedge clk);
      #1;
    end

    // clear wins over a same-cycle write
    prepare_frame(0);
    write_range(0, TOT - 1);
    clear = 1'b1; wen = 1'b1; data_in = 8'h55;
    @(posedge clk);
    #1 begin clear = 1'b0; wen = 1'b0; end
    check("clear_wr_full", 128'(wr_full), 0);
    write_range(0, TOT - 1);
    check("clr_prio_675", 128'(wr_full), 0);
    write_range(TOT - 1, TOT);
    check("clr_prio_676", 128'(wr_full), 1);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clear_full", 128'(wr_full), 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_after_clear_busy", 128'(busy), 0);
    @(posedge clk);
    #1 check("start_after_clear_valid", 128'(win_valid), 0);

    // reset while window 50 is presented
    write_range(0, TOT);
    win_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    acc = 0;
    cnt = 0;
    while (cnt < 1000 && !(win_valid && acc == 50)) begin
      if (win_valid) acc++;
      @(posedge clk);
      #1 cnt++;
    end
    check("abort_reached", 128'(win_valid && acc == 50), 1);
    check("abort_win_pos", 128'({win_row, win_col}), 128'({5'd3, 5'd11}));
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort_valid",   128'(win_valid), 0);
    check("abort_busy",    128'(busy), 0);
    check("abort_wr_full", 128'(wr_full), 0);
    seen_done = done;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 seen_done |= done;
    end
    check("abort_no_done", 128'(seen_done), 0);
    write_range(0, TOT);
    run_scan(1'b0, 1'b0);
    check("rescan_done_seen", 128'(done_cyc >= 0), 1);
    if (q.size() > 0) check("rescan_first", q[0].data, 128'h1b1a0100);
    else              check("rescan_first_present", 128'(q.size()), 169);
    @(posedge clk);
    #1;

`ifdef WINDOW_MAX_EN
    // signed maximum: mixed-sign and all-negative windows
    prepare_frame(2);
    write_range(0, TOT);
    run_scan(1'b1, 1'b0);
    if (q.size() > 1) begin
      check("max_mixed", 128'(q[0].mx), 128'(8'h03));
      check("max_neg",   128'(q[1].mx), 128'(8'hff));
    end else begin
      check("max_present", 128'(q.size()), 169);
    end
    verify_model(1'b0, "maxf");
    @(posedge clk);
    #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
